// File: rtl/tawas_pkg.sv
// tawas_pkg: shared sizes and the write-request record for the Tawas register file
package tawas_pkg;
  localparam int NUM_SLICES = 2;
  localparam int NUM_REGS = 8;
  localparam int REG_SEL_W = 3;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic vld;
    logic slice;
    logic [REG_SEL_W-1:0] sel;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/tawas_scoreboard.sv
// tawas_scoreboard: per-slice load busy bits and issue stall; TAWAS_REGFILE_BYPASS_EN lets a same-cycle load return hide its busy bit
module tawas_scoreboard import tawas_pkg::*; (
  input logic CLK,
  input logic RST,
  input logic slice,
  input logic [REG_SEL_W-1:0] ra_sel,
  input logic [REG_SEL_W-1:0] rb_sel,
  input logic set_vld,
  input logic set_slice,
  input logic [REG_SEL_W-1:0] set_sel,
  input logic clr_vld,
  input logic clr_slice,
  input logic [REG_SEL_W-1:0] clr_sel,
  output logic stall
);
  localparam int N = NUM_SLICES * NUM_REGS;
  logic [N-1:0] busy, set_mask, clr_mask, eff;
  assign set_mask = N'(set_vld) << {set_slice, set_sel};
  assign clr_mask = N'(clr_vld) << {clr_slice, clr_sel};
  // Set is applied after clear so a fresh load to a returning register stays outstanding
  always_ff @(posedge CLK or posedge RST)
    if (RST) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
`ifdef TAWAS_REGFILE_BYPASS_EN
  assign eff = busy & ~clr_mask;
`else
  assign eff = busy;
`endif
  assign stall = eff[{slice, ra_sel}] | eff[{slice, rb_sel}];
endmodule

// File: rtl/tawas_regfile.sv
// tawas_regfile: 2 slices x 8 regs banked register file with AU/LS write-back and load scoreboard
// Define TAWAS_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports
module tawas_regfile import tawas_pkg::*; #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic CLK,
  input logic RST,
  input logic SLICE,
  input logic [REG_SEL_W-1:0] AU_RA_SEL,
  output logic [DATA_W-1:0] AU_RA,
  input logic [REG_SEL_W-1:0] AU_RB_SEL,
  output logic [DATA_W-1:0] AU_RB,
  input logic AU_RC_VLD,
  input logic [REG_SEL_W-1:0] AU_RC_SEL,
  input logic [DATA_W-1:0] AU_RC,
  input logic LS_LD_ISSUE,
  input logic LS_LD_SLICE,
  input logic [REG_SEL_W-1:0] LS_LD_SEL,
  input logic LS_RC_VLD,
  input logic LS_RC_SLICE,
  input logic [REG_SEL_W-1:0] LS_RC_SEL,
  input logic [DATA_W-1:0] LS_RC,
  output logic RF_STALL,
  output logic RF_CONFLICT
);
  logic [DATA_W-1:0] bank [NUM_SLICES][NUM_REGS];
  logic slice_d1, conflict;
  wr_req_t au, ls;
  // AU results land one cycle after issue, so they belong to the previous slice
  assign au = '{vld: AU_RC_VLD, slice: slice_d1, sel: AU_RC_SEL, data: AU_RC};
  assign ls = '{vld: LS_RC_VLD, slice: LS_RC_SLICE, sel: LS_RC_SEL, data: LS_RC};
  assign conflict = au.vld && ls.vld && au.slice == ls.slice && au.sel == ls.sel;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      slice_d1 <= 1'b0;
      RF_CONFLICT <= 1'b0;
      for (int s = 0; s < NUM_SLICES; s++)
        for (int r = 0; r < NUM_REGS; r++)
          bank[s][r] <= RESET_VAL;
    end else begin
      slice_d1 <= SLICE;
      RF_CONFLICT <= conflict;
      if (ls.vld && !conflict) bank[ls.slice][ls.sel] <= ls.data;
      if (au.vld) bank[au.slice][au.sel] <= au.data;
    end
`ifdef TAWAS_REGFILE_BYPASS_EN
  logic au_a, au_b, ls_a, ls_b;
  assign au_a = au.vld && au.slice == SLICE && au.sel == AU_RA_SEL;
  assign au_b = au.vld && au.slice == SLICE && au.sel == AU_RB_SEL;
  assign ls_a = ls.vld && ls.slice == SLICE && ls.sel == AU_RA_SEL;
  assign ls_b = ls.vld && ls.slice == SLICE && ls.sel == AU_RB_SEL;
  assign AU_RA = au_a ? au.data : ls_a ? ls.data : bank[SLICE][AU_RA_SEL];
  assign AU_RB = au_b ? au.data : ls_b ? ls.data : bank[SLICE][AU_RB_SEL];
`else
  assign AU_RA = bank[SLICE][AU_RA_SEL];
  assign AU_RB = bank[SLICE][AU_RB_SEL];
`endif
  tawas_scoreboard u_sb (
    .CLK(CLK),
    .RST(RST),
    .slice(SLICE),
    .ra_sel(AU_RA_SEL),
    .rb_sel(AU_RB_SEL),
    .set_vld(LS_LD_ISSUE),
    .set_slice(LS_LD_SLICE),
    .set_sel(LS_LD_SEL),
    .clr_vld(LS_RC_VLD),
    .clr_slice(LS_RC_SLICE),
    .clr_sel(LS_RC_SEL),
    .stall(RF_STALL)
  );
endmodule

// File: tb/tb_tawas_regfile.sv
// tb_tawas_regfile: directed vector table, reset corner sequence and randomized model check of tawas_regfile
module tb_tawas_regfile;
`ifdef TAWAS_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] BV = BYP ? 32'hCAFE : 32'h0;
  localparam logic [31:0] B23_RA = BYP ? 32'd9 : 32'd7;
  localparam logic B23_ST = BYP ? 1'b0 : 1'b1;

  logic clk = 1'b0, rst;
  logic slice, au_vld, ld_iss, ld_slice, ls_vld, ls_slice, stall, conf;
  logic [2:0] ra_sel, rb_sel, au_sel, ld_sel, ls_sel;
  logic [31:0] ra, rb, au_data, ls_data;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  tawas_regfile dut (
    .CLK(clk), .RST(rst), .SLICE(slice),
    .AU_RA_SEL(ra_sel), .AU_RA(ra), .AU_RB_SEL(rb_sel), .AU_RB(rb),
    .AU_RC_VLD(au_vld), .AU_RC_SEL(au_sel), .AU_RC(au_data),
    .LS_LD_ISSUE(ld_iss), .LS_LD_SLICE(ld_slice), .LS_LD_SEL(ld_sel),
    .LS_RC_VLD(ls_vld), .LS_RC_SLICE(ls_slice), .LS_RC_SEL(ls_sel), .LS_RC(ls_data),
    .RF_STALL(stall), .RF_CONFLICT(conf)
  );

  typedef struct {
    logic sl; logic [2:0] ra, rb;
    logic av; logic [2:0] as; logic [31:0] ad;
    logic li, lis; logic [2:0] lsel;
    logic lv, lvs; logic [2:0] lvsel; logic [31:0] ld;
    logic [31:0] era, erb; logic est, ecf;
  } vec_t;
  vec_t tbl [26];

  logic [31:0] m_bank [2][8];
  logic m_busy [2][8];
  logic m_sd1, m_conf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    slice = v.sl; ra_sel = v.ra; rb_sel = v.rb;
    au_vld = v.av; au_sel = v.as; au_data = v.ad;
    ld_iss = v.li; ld_slice = v.lis; ld_sel = v.lsel;
    ls_vld = v.lv; ls_slice = v.lvs; ls_sel = v.lvsel; ls_data = v.ld;
  endtask

  task automatic idle(input logic sl, input logic [2:0] a, input logic [2:0] b);
    slice = sl; ra_sel = a; rb_sel = b;
    au_vld = 1'b0; au_sel = 3'd0; au_data = 32'd0;
    ld_iss = 1'b0; ld_slice = 1'b0; ld_sel = 3'd0;
    ls_vld = 1'b0; ls_slice = 1'b0; ls_sel = 3'd0; ls_data = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] r3();
    return ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] sel);
    if (BYP && au_vld && m_sd1 == slice && au_sel == sel) return au_data;
    if (BYP && ls_vld && ls_slice == slice && ls_sel == sel) return ls_data;
    return m_bank[slice][sel];
  endfunction

  function automatic logic m_busy_now(input logic [2:0] sel);
    if (BYP && ls_vld && ls_slice == slice && ls_sel == sel) return 1'b0;
    return m_busy[slice][sel];
  endfunction

  initial begin
    tbl[0]  = '{1'b0,3'd3,3'd5, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[1]  = '{1'b1,3'd3,3'd5, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[2]  = '{1'b0,3'd2,3'd2, 1'b1,3'd2,32'hDEADBEEF, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[3]  = '{1'b1,3'd2,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'hDEADBEEF,32'h0,1'b0,1'b0};
    tbl[4]  = '{1'b0,3'd2,3'd2, 1'b0,3'd0,32'h0, 1'b1,1'b0,3'd4, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[5]  = '{1'b1,3'd0,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[6]  = '{1'b0,3'd4,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b1,1'b0};
    tbl[7]  = '{1'b1,3'd2,3'd4, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b1,1'b0,3'd4,32'h1234, 32'hDEADBEEF,32'h0,1'b0,1'b0};
    tbl[8]  = '{1'b0,3'd4,3'd4, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h1234,32'h1234,1'b0,1'b0};
    tbl[9]  = '{1'b1,3'd6,3'd6, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[10] = '{1'b0,3'd6,3'd6, 1'b1,3'd6,32'h1, 1'b0,1'b0,3'd0, 1'b1,1'b1,3'd6,32'h2, 32'h0,32'h0,1'b0,1'b0};
    tbl[11] = '{1'b1,3'd6,3'd6, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h1,32'h1,1'b0,1'b1};
    tbl[12] = '{1'b0,3'd6,3'd6, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[13] = '{1'b1,3'd0,3'd0, 1'b0,3'd0,32'h0, 1'b1,1'b1,3'd1, 1'b1,1'b1,3'd1,32'h5, 32'h0,32'h0,1'b0,1'b0};
    tbl[14] = '{1'b0,3'd1,3'd1, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[15] = '{1'b1,3'd1,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h5,32'h0,1'b1,1'b0};
    tbl[16] = '{1'b0,3'd0,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b1,1'b1,3'd1,32'h7, 32'h0,32'h0,1'b0,1'b0};
    tbl[17] = '{1'b1,3'd1,3'd1, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h7,32'h7,1'b0,1'b0};
    tbl[18] = '{1'b0,3'd7,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b1,1'b0,3'd7,32'hCAFE, BV,32'h0,1'b0,1'b0};
    tbl[19] = '{1'b1,3'd1,3'd1, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h7,32'h7,1'b0,1'b0};
    tbl[20] = '{1'b0,3'd7,3'd7, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'hCAFE,32'hCAFE,1'b0,1'b0};
    tbl[21] = '{1'b1,3'd1,3'd1, 1'b0,3'd0,32'h0, 1'b1,1'b1,3'd1, 1'b0,1'b0,3'd0,32'h0, 32'h7,32'h7,1'b0,1'b0};
    tbl[22] = '{1'b0,3'd0,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[23] = '{1'b1,3'd1,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b1,1'b1,3'd1,32'h9, B23_RA,32'h0,B23_ST,1'b0};
    tbl[24] = '{1'b0,3'd0,3'd0, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h0,32'h0,1'b0,1'b0};
    tbl[25] = '{1'b1,3'd1,3'd1, 1'b0,3'd0,32'h0, 1'b0,1'b0,3'd0, 1'b0,1'b0,3'd0,32'h0, 32'h9,32'h9,1'b0,1'b0};

    rst = 1'b1;
    idle(1'b0, 3'd3, 3'd5);
    @(negedge clk);
    chk("reset_ra", ra, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_conflict", 32'(conf), 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d_ra", i), ra, tbl[i].era);
      chk($sformatf("row%0d_rb", i), rb, tbl[i].erb);
      chk($sformatf("row%0d_stall", i), 32'(stall), 32'(tbl[i].est));
      chk($sformatf("row%0d_conflict", i), 32'(conf), 32'(tbl[i].ecf));
      tick();
    end

    // Reset in the middle of a cycle with a load outstanding and a conflict pulse live
    idle(1'b1, 3'd0, 3'd0);
    ld_iss = 1'b1; ld_slice = 1'b0; ld_sel = 3'd3;
    tick();
    idle(1'b0, 3'd3, 3'd7);
    au_vld = 1'b1; au_sel = 3'd6; au_data = 32'd9;
    ls_vld = 1'b1; ls_slice = 1'b1; ls_sel = 3'd6; ls_data = 32'd8;
    @(negedge clk);
    chk("mid_pre_stall", 32'(stall), 32'h1);
    chk("mid_pre_rb", rb, 32'hCAFE);
    tick();
    idle(1'b1, 3'd6, 3'd6);
    @(negedge clk);
    chk("mid_au_wins", ra, 32'd9);
    chk("mid_conflict", 32'(conf), 32'h1);
    idle(1'b0, 3'd3, 3'd7);
    #1;
    chk("mid_busy_before", 32'(stall), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ra", ra, 32'h0);
    chk("mid_rst_rb", rb, 32'h0);
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_conflict", 32'(conf), 32'h0);
    tick();
    rst = 1'b0;
    idle(1'b0, 3'd3, 3'd3);
    ls_vld = 1'b1; ls_slice = 1'b0; ls_sel = 3'd3; ls_data = 32'd55;
    @(negedge clk);
    chk("post_rst_ra", ra, BYP ? 32'd55 : 32'd0);
    chk("post_rst_stall", 32'(stall), 32'h0);
    tick();
    idle(1'b1, 3'd6, 3'd6);
    @(negedge clk);
    chk("post_rst_s1r6", ra, 32'h0);
    tick();
    idle(1'b0, 3'd3, 3'd7);
    @(negedge clk);
    chk("post_rst_ls_write", ra, 32'd55);
    chk("post_rst_r7", rb, 32'h0);
    tick();

    // Randomized run against an array-based reference model
    rst = 1'b1;
    idle(1'b1, 3'd0, 3'd0);
    tick();
    rst = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int r = 0; r < 8; r++) begin
        m_bank[s][r] = 32'h0;
        m_busy[s][r] = 1'b0;
      end
    m_sd1 = 1'b0;
    m_conf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic cf;
      slice = ~slice; ra_sel = r3(); rb_sel = r3();
      au_vld = 1'($urandom); au_sel = r3(); au_data = $urandom;
      ld_iss = ($urandom_range(0, 3) == 0); ld_slice = 1'($urandom); ld_sel = r3();
      ls_vld = ($urandom_range(0, 2) == 0); ls_slice = 1'($urandom); ls_sel = r3(); ls_data = $urandom;
      @(negedge clk);
      chk("rnd_ra", ra, m_read(ra_sel));
      chk("rnd_rb", rb, m_read(rb_sel));
      chk("rnd_stall", 32'(stall), 32'(m_busy_now(ra_sel) | m_busy_now(rb_sel)));
      chk("rnd_conflict", 32'(conf), 32'(m_conf));
      cf = au_vld && ls_vld && m_sd1 == ls_slice && au_sel == ls_sel;
      if (ls_vld && !cf) m_bank[ls_slice][ls_sel] = ls_data;
      if (au_vld) m_bank[m_sd1][au_sel] = au_data;
      if (ls_vld) m_busy[ls_slice][ls_sel] = 1'b0;
      if (ld_iss) m_busy[ld_slice][ld_sel] = 1'b1;
      m_conf = cf;
      m_sd1 = slice;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tawas_regfile.md
Name: tawas_regfile

Overview:
- Banked register file serving the Tawas arithmetic unit: two thread slices × 8 registers × 32 bits.
- Provides the combinational read data for the AU's A and B selects for the current slice.
- Accepts the AU write-back one cycle after issue, plus a load/store unit write-back.
- Keeps a per-slice load scoreboard so that an operand still pending from a load stalls issue.

Parameters:
- DATA_W, 32, register width; the AU interface requires 32.
- RESET_VAL, 32'd0, value loaded into every register on reset.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, asynchronous, active-high
- SLICE  input  1  current issue slice (thread 0/1); toggles every cycle
- AU_RA_SEL  input  3  A operand select, current slice
- AU_RA  output  32  A operand data
- AU_RB_SEL  input  3  B operand select, current slice
- AU_RB  output  32  B operand data
- AU_RC_VLD  input  1  AU write-back valid
- AU_RC_SEL  input  3  AU write-back register
- AU_RC  input  32  AU write-back data
- LS_LD_ISSUE  input  1  load issued; destination becomes busy
- LS_LD_SLICE  input  1  slice of the issued load
- LS_LD_SEL  input  3  destination register of the issued load
- LS_RC_VLD  input  1  load data return valid
- LS_RC_SLICE  input  1  slice of the returned data
- LS_RC_SEL  input  3  register of the returned data
- LS_RC  input  32  returned load data
- RF_STALL  output  1  current-slice operand is busy
- RF_CONFLICT  output  1  registered; pulses when an LS write was dropped

Behaviour:
- Storage: bank[s][r], s in {0,1}, r in 0..7. Reset (asynchronous) sets every entry to RESET_VAL.
- Reads are combinational: AU_RA = bank[SLICE][AU_RA_SEL], AU_RB = bank[SLICE][AU_RB_SEL]. Zero latency; the AU registers them.
- AU write bank: slice_d1, a flop of SLICE that resets to 0. AU results arrive one cycle after issue, when SLICE has already toggled.
  - On AU_RC_VLD: bank[slice_d1][AU_RC_SEL] <= AU_RC at the next edge.
- LS write: on LS_RC_VLD, bank[LS_RC_SLICE][LS_RC_SEL] <= LS_RC.
- Simultaneous writes:
  - Different bank or different register: both commit in the same cycle.
  - Same bank and same register: the AU write wins, the LS data is dropped, and RF_CONFLICT = 1 in the next cycle only.
- Scoreboard busy[s][r], reset to 0.
  - LS_LD_ISSUE sets busy[LS_LD_SLICE][LS_LD_SEL].
  - LS_RC_VLD clears busy[LS_RC_SLICE][LS_RC_SEL].
  - Set and clear to the same entry in the same cycle: set wins (a new load is outstanding).
  - Set of an entry that is already busy: it stays busy (no counting; one outstanding load per register).
- RF_STALL (combinational) = busy[SLICE][AU_RA_SEL] | busy[SLICE][AU_RB_SEL]. The caller decides whether B is used as an immediate; this block always checks both selects.
- AU write to a busy register does not clear busy.
- Same-cycle write then read (no bypass build): the read returns the old value; the new value is visible from the next cycle.
- Reset mid-operation: all banks, busy bits, slice_d1 and RF_CONFLICT clear immediately. Outstanding loads are forgotten; a later LS_RC_VLD still writes.
- Reset values of outputs:
  - AU_RA/AU_RB = RESET_VAL.
  - RF_STALL = 0.
  - RF_CONFLICT = 0.

Optional Feature:
- TAWAS_REGFILE_BYPASS_EN defined:
  - AU_RA/AU_RB forward same-cycle write data when the write bank equals SLICE and the register matches. AU has priority over LS.
  - RF_STALL ignores a busy bit whose clearing LS write is in the current cycle.
- Not defined: no forwarding; the behaviour is exactly as above.

Decomposition:
- Shared package tawas_pkg holds:
  - NUM_SLICES = 2, NUM_REGS = 8, REG_SEL_W = 3, DATA_W = 32.
  - A typedef for a write request {vld, slice, sel, data}.
- One natural sub-module, tawas_scoreboard: busy bits, set/clear priority and stall generation.

Test Plan:
- Reset, then AU_RA_SEL=3, AU_RB_SEL=5 on each slice -> AU_RA = AU_RB = 0, RF_STALL = 0.
- SLICE=1 at cycle t, then AU_RC_VLD=1, SEL=2, RC=32'hDEAD_BEEF at t+1 (SLICE=0) -> read on a later slice-1 cycle with SEL=2 returns DEADBEEF; slice 0 r2 is still 0.
- LS_LD_ISSUE slice 0, r4; later a slice-0 read of RA_SEL=4 -> RF_STALL = 1.
  - LS_RC_VLD slice 0, r4, 32'h1234 -> next cycle RF_STALL = 0 and AU_RA = 32'h1234.
- AU write and LS write to the same bank, r6, same cycle (AU=32'h1, LS=32'h2) -> r6 = 1; RF_CONFLICT pulses high for exactly one cycle.
- Same-cycle LS_LD_ISSUE and LS_RC_VLD to slice 1, r1 -> busy stays set; RF_STALL = 1 on the next slice-1 read of r1.
- With the macro: LS write slice 0, r7 = 32'hCAFE while SLICE=0, RA_SEL=7 -> AU_RA = CAFE the same cycle. Without the macro: the old value that cycle, CAFE the next.
